// File: rtl/l1a_trigger_throttle.sv
// ============================================================================
// Module   : l1a_trigger_throttle
// Purpose  : Queues raw trigger pulses and issues spaced, burst-limited L1As
//            with a wrapping event ID over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1a_trigger_throttle #(
  parameter int MIN_SPACING = 4,
  parameter int MAX_BURST   = 8,
  parameter int REFILL      = 64,
  parameter int DEPTH       = 4,
  parameter int EVID_W      = 12,
  localparam int TOK_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              trig_i,
  output logic              l1a_valid_o,
  input  logic              l1a_ready_i,
  output logic [EVID_W-1:0] evid_o,
  output logic              full_o,
  output logic              drop_o,
  output logic [15:0]       drop_cnt_o,
  output logic [TOK_W-1:0]  tokens_o
);

  localparam int PEND_W = $clog2(DEPTH + 1);
  localparam int RCNT_W = (REFILL > 1) ? $clog2(REFILL) : 1;
  localparam int SPC_W  = (MIN_SPACING > 2) ? $clog2(MIN_SPACING - 1) : 1;

  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(DEPTH);
  localparam logic [TOK_W-1:0]  TOK_MAX   = TOK_W'(MAX_BURST);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFILL - 1);
  localparam logic [SPC_W-1:0]  SPC_LOAD  = SPC_W'(MIN_SPACING - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PEND_W-1:0] pend;
  logic [PEND_W-1:0] pend_next;
  logic [TOK_W-1:0]  tokens;
  logic [TOK_W-1:0]  tokens_next;
  logic [RCNT_W-1:0] rcnt;
  logic [SPC_W-1:0]  spc;
  logic [SPC_W-1:0]  spc_next;
  logic [EVID_W-1:0] evid;
  logic              evid_inc;
  logic              hs;
  logic              trig_en;
  logic              accept;
  logic              refill_wrap;

  assign l1a_valid_o = (state == ISSUE);
  assign hs          = l1a_valid_o & l1a_ready_i;
  assign evid_o      = evid;
  assign tokens_o    = tokens;

  // A handshake frees a slot in the same cycle, so a trigger at full is kept.
  always_comb begin
    trig_en     = trig_i & enable_i;
    accept      = trig_en & ((pend != PEND_MAX) | hs);
    pend_next   = pend + PEND_W'(accept) - PEND_W'(hs);
    refill_wrap = (rcnt == RCNT_LAST);
    tokens_next = tokens;
    if (hs && !refill_wrap) begin
      tokens_next = tokens - TOK_W'(1);
    end else if (refill_wrap && !hs && (tokens != TOK_MAX)) begin
      tokens_next = tokens + TOK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    spc_next   = spc;
    evid_inc   = 1'b0;
    case (state)
      IDLE: begin
        if ((pend != '0) && (tokens != '0)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          state_next = HOLDOFF;
          spc_next   = SPC_LOAD;
          evid_inc   = 1'b1;
        end
      end
      HOLDOFF: begin
        // Decide on post-edge values so a back-to-back backlog keeps exact spacing.
        if (spc == '0) begin
          state_next = ((pend_next != '0) && (tokens_next != '0)) ? ISSUE : IDLE;
        end else begin
          spc_next = spc - SPC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      tokens     <= TOK_MAX;
      rcnt       <= '0;
      spc        <= '0;
      evid       <= '0;
      full_o     <= 1'b0;
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      pend   <= pend_next;
      tokens <= tokens_next;
      rcnt   <= refill_wrap ? '0 : rcnt + RCNT_W'(1);
      spc    <= spc_next;
      full_o <= (pend_next == PEND_MAX);
      drop_o <= trig_en & ~accept;
      if (evid_inc) begin
        evid <= evid + EVID_W'(1);
      end
      if (trig_en && !accept && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
